// File: rtl/mult_div_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  localparam int MD_MAX_WIDTH = 64;
  // Sliced down to the instance width where used.
  localparam logic [MD_MAX_WIDTH-1:0] MD_DIV0_LO = '1;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Issue/result bundle between execute stage (master) and the multiply/divide unit (slave).
// Handshake: start is taken only when busy is low; done pulses one cycle when a MULT/DIV result lands in hi/lo.
interface mult_div_if #(parameter int WIDTH = 32);
  import mult_div_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  md_state_t        state;

  modport master (output start, op, rs_data, rt_data,
                  input  busy, done, hi, lo, state);
  modport slave  (input  start, op, rs_data, rt_data,
                  output busy, done, hi, lo, state);
endinterface

// File: rtl/mult_div_divider.sv
// Restoring divide datapath: unsigned, one quotient bit per enabled cycle.
// Next-step values are exposed so the caller can fold sign fix-up into the final edge.
module mult_div_divider #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH:0]   shifted, diff;

  // A set top bit of diff is the borrow: partial remainder smaller than divisor.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, dvs};
    quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (en) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Define MULT_DIV_FAST_MULT_EN for a single-cycle combinational multiply.
module mult_div_unit
  import mult_div_pkg::*;
#(parameter int WIDTH = 32) (
  input logic      clk,
  input logic      reset,
  mult_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  md_state_t        state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q, rs_raw, abs_rs, abs_rt;
  logic [WIDTH-1:0] quo_next, rem_next, quo_fix, rem_fix;
  logic             done_q, neg_res, neg_rem, div_zero;
  logic             accept, is_mul, is_div, sgn, last, finish;

  assign accept = (state == ST_IDLE) && bus.start;
  assign is_mul = accept && (bus.op == OP_MULT || bus.op == OP_MULTU);
  assign is_div = accept && (bus.op == OP_DIV || bus.op == OP_DIVU);
  assign sgn    = is_signed_op(bus.op);
  assign abs_rs = (sgn && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
  assign abs_rt = (sgn && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_next = state;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_div) state_next = ST_DIV;
`ifndef MULT_DIV_FAST_MULT_EN
        else if (is_mul) state_next = ST_MUL;
`endif
      end
`ifndef MULT_DIV_FAST_MULT_EN
      ST_MUL: if (last) begin
        state_next = ST_IDLE;
        finish     = 1'b1;
      end
`endif
      ST_DIV: if (last) begin
        state_next = ST_IDLE;
        finish     = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state != ST_IDLE) cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Sign flags and the raw dividend are captured at the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      neg_res  <= sgn && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
      neg_rem  <= sgn && bus.rs_data[WIDTH-1];
      div_zero <= (bus.rt_data == '0);
      rs_raw   <= bus.rs_data;
    end
  end

`ifdef MULT_DIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = sgn ?
    {{WIDTH{bus.rs_data[WIDTH-1]}}, bus.rs_data} * {{WIDTH{bus.rt_data[WIDTH-1]}}, bus.rt_data} :
    {{WIDTH{1'b0}}, bus.rs_data} * {{WIDTH{1'b0}}, bus.rt_data};
`else
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod, mul_step, mul_res;
  logic [WIDTH:0]     mul_sum;

  // Upper half accumulates, lower half holds the unconsumed multiplier bits.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    mul_step = {mul_sum, prod[WIDTH-1:1]};
    mul_res  = neg_res ? -mul_step : mul_step;
  end

  always_ff @(posedge clk) begin
    if (is_mul) begin
      mcand <= abs_rs;
      prod  <= {{WIDTH{1'b0}}, abs_rt};
    end else if (state == ST_MUL) begin
      prod <= mul_step;
    end
  end
`endif

  mult_div_divider #(.WIDTH(WIDTH)) u_divider (
    .clk      (clk),
    .load     (is_div),
    .en       (state == ST_DIV),
    .dividend (abs_rs),
    .divisor  (abs_rt),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  assign quo_fix = neg_res ? -quo_next : quo_next;
  assign rem_fix = neg_rem ? -rem_next : rem_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (accept && bus.op == OP_MTHI) begin
      hi_q <= bus.rs_data;
    end else if (accept && bus.op == OP_MTLO) begin
      lo_q <= bus.rs_data;
`ifdef MULT_DIV_FAST_MULT_EN
    end else if (is_mul) begin
      hi_q <= fast_prod[2*WIDTH-1:WIDTH];
      lo_q <= fast_prod[WIDTH-1:0];
`else
    end else if (state == ST_MUL && finish) begin
      hi_q <= mul_res[2*WIDTH-1:WIDTH];
      lo_q <= mul_res[WIDTH-1:0];
`endif
    end else if (state == ST_DIV && finish) begin
      if (div_zero) begin
        lo_q <= MD_DIV0_LO[WIDTH-1:0];
        hi_q <= rs_raw;
      end else begin
        lo_q <= quo_fix;
        hi_q <= rem_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
`ifdef MULT_DIV_FAST_MULT_EN
    else       done_q <= finish || is_mul;
`else
    else       done_q <= finish;
`endif
  end

  assign bus.busy  = (state != ST_IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = state;
endmodule
